// File: rtl/wb_cmd_pkg.sv
// rtl/wb_cmd_pkg.sv - shared types and constants for the Wishbone command master
package wb_cmd_pkg;

  localparam int DEF_ADR_W       = 32;
  localparam int DEF_DAT_W       = 32;

  localparam int RSP_STATUS_W    = 2;
  localparam int RSP_ERR_BIT     = 0;
  localparam int RSP_TIMEOUT_BIT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RSP
  } state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - bus-cycle watchdog; expired flags the last permitted cycle
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + ONE;
  end

  // High during the TIMEOUT_CYCLES-th busy cycle, so cyc drops at the following edge.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone pipelined initiator with timeout
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int ADR_W          = DEF_ADR_W,
  parameter int DAT_W          = DEF_DAT_W,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W         = DAT_W / 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0] cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic             rsp_timeout_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0] wb_sel_o,
  input  logic             wb_stall_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic [DAT_W-1:0] wb_dat_i
);

  state_t                  state, state_n;
  logic                    cyc_n, stb_n, we_n, rsp_valid_n;
  logic [ADR_W-1:0]        adr_n;
  logic [DAT_W-1:0]        dat_n, rsp_dat_n;
  logic [SEL_W-1:0]        sel_n;
  logic [RSP_STATUS_W-1:0] status, status_n;
  logic                    complete, abort, expired;

  wb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (state == S_IDLE && cmd_valid_i),
    .enable  (state == S_REQ || state == S_WAIT),
    .expired (expired)
  );

  assign cmd_ready_o   = (state == S_IDLE);
  assign rsp_err_o     = status[RSP_ERR_BIT];
  assign rsp_timeout_o = status[RSP_TIMEOUT_BIT];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      status      <= '0;
    end else begin
      state       <= state_n;
      wb_cyc_o    <= cyc_n;
      wb_stb_o    <= stb_n;
      wb_we_o     <= we_n;
      wb_adr_o    <= adr_n;
      wb_dat_o    <= dat_n;
      wb_sel_o    <= sel_n;
      rsp_valid_o <= rsp_valid_n;
      rsp_dat_o   <= rsp_dat_n;
      status      <= status_n;
    end
  end

  always_comb begin
    state_n     = state;
    cyc_n       = wb_cyc_o;
    stb_n       = wb_stb_o;
    we_n        = wb_we_o;
    adr_n       = wb_adr_o;
    dat_n       = wb_dat_o;
    sel_n       = wb_sel_o;
    rsp_valid_n = rsp_valid_o;
    rsp_dat_n   = rsp_dat_o;
    status_n    = status;
    complete    = 1'b0;
    abort       = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_n    = cmd_we_i;
          adr_n   = cmd_adr_i;
          dat_n   = cmd_dat_i;
          sel_n   = cmd_sel_i;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        // A response only counts once the request itself has been accepted.
        if (!wb_stall_i && (wb_ack_i || wb_err_i)) complete = 1'b1;
        else if (expired)                          abort    = 1'b1;
        else if (!wb_stall_i) begin
          stb_n   = 1'b0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wb_ack_i || wb_err_i) complete = 1'b1;
        else if (expired)         abort    = 1'b1;
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (complete || abort) begin
      cyc_n       = 1'b0;
      stb_n       = 1'b0;
      rsp_valid_n = 1'b1;
      state_n     = S_RSP;
      rsp_dat_n   = '0;
      status_n    = '0;
      if (abort)         status_n[RSP_TIMEOUT_BIT] = 1'b1;
      else if (wb_err_i) status_n[RSP_ERR_BIT]     = 1'b1;
      else if (!wb_we_o) rsp_dat_n                 = wb_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

  localparam int TO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  int checks = 0;
  int errors = 0;

  wb_cmd_master #(.ADR_W(32), .DAT_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .cmd_sel_i     (cmd_sel_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel_o),
    .wb_stall_i    (wb_stall_i),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i),
    .wb_dat_i      (wb_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // resp_at: cyc-high cycle (1 = first) in which the slave drives ack/err; 0 = slave silent.
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int stall, input int resp_at,
                        input logic e, input logic a, input logic [31:0] rd, input int hold);
    logic        honored, normal, exp_err, done;
    logic [31:0] exp_dat;
    int          exp_cyc, exp_stb, cyc_cnt, stb_cnt, n;
    honored = (resp_at != 0) && (resp_at > stall) && (a || e);
    normal  = honored && (resp_at <= TO);
    exp_cyc = normal ? resp_at : TO;
    exp_stb = (stall + 1 < exp_cyc) ? stall + 1 : exp_cyc;
    exp_err = normal && e;
    exp_dat = (normal && !e && !we) ? rd : 32'h0;

    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    @(negedge wb_clk_i);
    chk("cmd_ready_idle", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    cmd_we_i = $urandom_range(0, 1); cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom_range(0, 15));

    n = 1; cyc_cnt = 0; stb_cnt = 0; done = 1'b0;
    while (!done && n <= 40) begin
      wb_stall_i = (n <= stall);
      wb_ack_i   = (n == resp_at) && a;
      wb_err_i   = (n == resp_at) && e;
      wb_dat_i   = (n == resp_at) ? rd : $urandom;
      @(negedge wb_clk_i);
      if (wb_cyc_o) begin
        cyc_cnt++;
        if (wb_stb_o) stb_cnt++;
        chk("bus_fields_stable", {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}, {we, adr, dat, sel});
        chk("no_rsp_during_cyc", {rsp_valid_o, cmd_ready_o}, 2'b00);
        tick();
        n++;
      end else begin
        done = 1'b1;
      end
    end
    chk("cyc_drop_bound", done, 1);
    chk("cyc_cycles", cyc_cnt, exp_cyc);
    chk("stb_cycles", stb_cnt, exp_stb);
    chk("rsp_first", {rsp_valid_o, wb_stb_o, rsp_err_o, rsp_timeout_o, rsp_dat_o},
        {1'b1, 1'b0, exp_err, !normal, exp_dat});
    chk("adr_kept", wb_adr_o, adr);
    tick();
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

    repeat (hold) begin
      @(negedge wb_clk_i);
      chk("rsp_hold", {rsp_valid_o, cmd_ready_o, rsp_err_o, rsp_timeout_o, rsp_dat_o},
          {1'b1, 1'b0, exp_err, !normal, exp_dat});
      tick();
    end
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    chk("rsp_handshake", {rsp_valid_o, rsp_dat_o}, {1'b1, exp_dat});
    tick();
    rsp_ready_i = 1'b0;
    @(negedge wb_clk_i);
    chk("back_to_idle", {rsp_valid_o, cmd_ready_o, wb_cyc_o}, 3'b010);
    tick();
  endtask

  logic        r_we, r_e, r_a;
  logic [3:0]  r_sel;
  int          r_stall, r_resp, r_hold;

  initial begin
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("reset_ctrl", {cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o},
        7'b1000000);
    chk("reset_data", {wb_adr_o, rsp_dat_o}, 64'h0);
    tick();
    wb_rst_i = 1'b0;
    tick();

    // write, read with held response, stalled request, err+ack, timeout, ack on last cycle
    do_cmd(1'b1, 32'h0, 32'h1, 4'h1, 0, 2, 1'b0, 1'b1, 32'h0, 0);
    do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 0, 2, 1'b0, 1'b1, 32'hDEADBEEF, 4);
    do_cmd(1'b1, 32'h24, 32'hA5A5_0F0F, 4'h3, 3, 5, 1'b0, 1'b1, 32'h0, 1);
    do_cmd(1'b0, 32'h30, 32'h0, 4'hF, 0, 2, 1'b1, 1'b1, 32'h1234_5678, 0);
    do_cmd(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 32'h0, 0);
    do_cmd(1'b0, 32'h44, 32'h0, 4'hF, 0, TO, 1'b0, 1'b1, 32'hCAFE_F00D, 0);
    do_cmd(1'b0, 32'h48, 32'h0, 4'hF, 0, TO + 1, 1'b0, 1'b1, 32'hCAFE_F00D, 0);
    do_cmd(1'b0, 32'h4C, 32'h0, 4'hF, 2, 3, 1'b1, 1'b0, 32'h5555_AAAA, 0);
    do_cmd(1'b0, 32'h50, 32'h0, 4'hF, 2, 2, 1'b0, 1'b1, 32'h5555_AAAA, 0);

    // spurious responses while idle
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge wb_clk_i);
      chk("spurious_idle", {rsp_valid_o, cmd_ready_o, wb_cyc_o}, 3'b010);
      tick();
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;

    // asynchronous reset while waiting for ack
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h60; cmd_sel_i = 4'hF;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    @(negedge wb_clk_i);
    chk("in_wait", {wb_cyc_o, wb_stb_o}, 2'b10);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("async_reset_drop", {wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o}, 4'b0001);
    tick();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("after_reset", {rsp_valid_o, cmd_ready_o, wb_cyc_o}, 3'b010);
    tick();
    do_cmd(1'b0, 32'h64, 32'h0, 4'hF, 1, 3, 1'b0, 1'b1, 32'h0BAD_F00D, 1);

    for (int i = 0; i < 40; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_e     = 1'($urandom_range(0, 1));
      r_a     = 1'($urandom_range(0, 1));
      r_sel   = 4'($urandom_range(0, 15));
      r_stall = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
      r_resp  = int'($urandom_range(0, 11));
      r_hold  = int'($urandom_range(0, 3));
      do_cmd(r_we, $urandom, $urandom, r_sel, r_stall, r_resp, r_e, r_a, $urandom, r_hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
